// File: rtl/int_reg_pkg.sv
// Shared types and widths for the interrupt-controller register bus.
// Both the master and the bank's own select logic import these.
package int_reg_pkg;

    localparam int unsigned INT_REG_AW     = 32;
    localparam int unsigned INT_REG_DW     = 32;
    localparam int unsigned INT_REG_STRIDE = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } int_reg_state_e;

    // Index width that stays legal for a single-register bank.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_reg_addr_dec.sv
// Byte address -> register hit, index and one-hot select for the register bank.
// Compares in 33 bits so ranges near the top of the address space cannot wrap.
module int_reg_addr_dec
    import int_reg_pkg::*;
#(
    parameter int unsigned           NUM_REGS  = 8,
    parameter logic [INT_REG_AW-1:0] BASE_ADDR = 32'h0C00_0000,
    parameter int unsigned           IDX_W     = idx_width(NUM_REGS)
) (
    input  logic [INT_REG_AW-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index,
    output logic [NUM_REGS-1:0]   sel
);

    logic [INT_REG_AW:0] addr_ext;
    logic [INT_REG_AW:0] base_ext;
    logic [INT_REG_AW:0] limit_ext;
    logic [INT_REG_AW:0] offset;

    always_comb begin
        addr_ext  = {1'b0, addr};
        base_ext  = {1'b0, BASE_ADDR};
        limit_ext = base_ext + (INT_REG_AW+1)'(INT_REG_STRIDE * NUM_REGS);
        offset    = addr_ext - base_ext;
        hit       = (addr_ext >= base_ext) && (addr_ext < limit_ext) && (addr[1:0] == 2'b00);
        index     = IDX_W'(offset >> 2);
        sel       = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            sel[i] = hit && (index == IDX_W'(i));
        end
    end

endmodule

// File: rtl/int_reg_master.sv
// Single-outstanding bus initiator for the interrupt-controller register bank.
// Turns one core request into one register-bus cycle and returns a response.
module int_reg_master
    import int_reg_pkg::*;
#(
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [INT_REG_AW-1:0] BASE_ADDR  = 32'h0C00_0000,
    parameter int unsigned           REG_STRIDE = INT_REG_STRIDE
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_wr,
    input  logic [INT_REG_AW-1:0]          req_addr,
    input  logic [INT_REG_DW-1:0]          req_wdata,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [INT_REG_DW-1:0]          resp_rdata,
    output logic                           resp_err,
    output logic                           reg_en,
    output logic                           reg_wr,
    output logic [INT_REG_AW-1:0]          reg_addr,
    output logic [INT_REG_DW-1:0]          reg_wdata,
    output logic [NUM_REGS-1:0]            reg_sel,
    input  logic [NUM_REGS*INT_REG_DW-1:0] reg_rdata_vec
);

    localparam int unsigned IDX_W = idx_width(NUM_REGS);
    // The decoder assumes 4-byte spacing; any other stride maps nothing.
    localparam bit STRIDE_OK = (REG_STRIDE == INT_REG_STRIDE);

    int_reg_state_e        state;
    logic [IDX_W-1:0]      idx_q;
    logic                  dec_hit;
    logic                  map_hit;
    logic [IDX_W-1:0]      dec_index;
    logic [NUM_REGS-1:0]   dec_sel;
    logic [INT_REG_DW-1:0] rd_word;

    int_reg_addr_dec #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_addr_dec (
        .addr  (req_addr),
        .hit   (dec_hit),
        .index (dec_index),
        .sel   (dec_sel)
    );

    assign map_hit   = dec_hit && STRIDE_OK;
    assign req_ready = (state == StIdle);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_word = reg_rdata_vec[i*INT_REG_DW +: INT_REG_DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StIdle;
            idx_q      <= '0;
            reg_en     <= 1'b0;
            reg_wr     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_sel    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        if (map_hit) begin
                            state     <= StAccess;
                            idx_q     <= dec_index;
                            reg_en    <= 1'b1;
                            reg_wr    <= req_wr;
                            reg_addr  <= req_addr;
                            reg_wdata <= req_wdata;
                            reg_sel   <= dec_sel;
                        end else begin
                            // Unmapped or misaligned: answer without touching the bus.
                            state      <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                StAccess: begin
                    state      <= StResp;
                    reg_en     <= 1'b0;
                    reg_wr     <= 1'b0;
                    reg_sel    <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= reg_wr ? '0 : rd_word;
                end
                StResp: begin
                    if (resp_ready) begin
                        state      <= StIdle;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_int_reg_master.sv
// Directed bench for int_reg_master with a behavioural register bank attached.
module tb_int_reg_master;

    localparam int unsigned NUM_REGS = 8;
    localparam logic [31:0] BASE     = 32'h0C00_0000;

    logic                     clk;
    logic                     rstn;
    logic                     bank_rstn;
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_wr;
    logic [31:0]              req_addr;
    logic [31:0]              req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [31:0]              resp_rdata;
    logic                     resp_err;
    logic                     reg_en;
    logic                     reg_wr;
    logic [31:0]              reg_addr;
    logic [31:0]              reg_wdata;
    logic [NUM_REGS-1:0]      reg_sel;
    logic [NUM_REGS*32-1:0]   reg_rdata_vec;

    logic [31:0] bank [NUM_REGS];
    int          en_cnt;
    int          bus_viol;
    logic        en_prev;
    int          errors;
    int          checks;
    int          en_base;

    int_reg_master #(
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE),
        .REG_STRIDE (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .reg_en        (reg_en),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_sel       (reg_sel),
        .reg_rdata_vec (reg_rdata_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder bank; its own reset so a master reset cannot mask a dropped write.
    always @(posedge clk or negedge bank_rstn) begin
        if (!bank_rstn) begin
            for (int i = 0; i < int'(NUM_REGS); i++) bank[i] <= 32'hA5A5_0000 + 32'(i);
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (reg_en && reg_wr && reg_sel[i]) bank[i] <= reg_wdata;
            end
        end
    end

    always_comb begin
        reg_rdata_vec = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) reg_rdata_vec[i*32 +: 32] = bank[i];
    end

    always @(posedge clk) begin
        if (reg_en) en_cnt <= en_cnt + 1;
        if ((reg_en && en_prev) || ($countones(reg_sel) > 1) || (reg_sel != '0 && !reg_en))
            bus_viol <= bus_viol + 1;
        en_prev <= reg_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        errors = 0; checks = 0; en_cnt = 0; bus_viol = 0; en_prev = 1'b0;
        rstn = 1'b1; bank_rstn = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_reg_sel", 32'(reg_sel), 32'd0);
        chk("rst_reg_addr", reg_addr, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1; bank_rstn = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            chk("idle_reg_en", 32'(reg_en), 32'd0);
        end

        // Write DEADBEEF to register 2.
        en_base = en_cnt;
        resp_ready = 1'b1;
        drive(1'b1, BASE + 32'd8, 32'hDEAD_BEEF);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_acc_reg_en", 32'(reg_en), 32'd1);
        chk("wr_acc_reg_wr", 32'(reg_wr), 32'd1);
        chk("wr_acc_reg_sel", 32'(reg_sel), 32'h04);
        chk("wr_acc_reg_addr", reg_addr, BASE + 32'd8);
        chk("wr_acc_reg_wdata", reg_wdata, 32'hDEAD_BEEF);
        chk("wr_acc_req_ready", 32'(req_ready), 32'd0);
        chk("wr_acc_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("wr_resp_valid", 32'(resp_valid), 32'd1);
        chk("wr_resp_err", 32'(resp_err), 32'd0);
        chk("wr_resp_rdata", resp_rdata, 32'd0);
        chk("wr_resp_reg_en", 32'(reg_en), 32'd0);
        chk("wr_resp_reg_sel", 32'(reg_sel), 32'd0);
        @(negedge clk);
        chk("wr_done_resp_valid", 32'(resp_valid), 32'd0);
        chk("wr_done_req_ready", 32'(req_ready), 32'd1);
        chk("wr_bank2", bank[2], 32'hDEAD_BEEF);
        chk("wr_en_pulses", 32'(en_cnt), 32'(en_base + 1));

        // Read it back.
        drive(1'b0, BASE + 32'd8, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rd_acc_reg_en", 32'(reg_en), 32'd1);
        chk("rd_acc_reg_wr", 32'(reg_wr), 32'd0);
        chk("rd_acc_reg_sel", 32'(reg_sel), 32'h04);
        @(negedge clk);
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("rd_resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);

        // Unmapped read, misaligned write, below-base read.
        en_base = en_cnt;
        drive(1'b0, BASE + 32'd32, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("oor_resp_valid", 32'(resp_valid), 32'd1);
        chk("oor_resp_err", 32'(resp_err), 32'd1);
        chk("oor_resp_rdata", resp_rdata, 32'd0);
        chk("oor_reg_en", 32'(reg_en), 32'd0);
        @(negedge clk);
        drive(1'b1, BASE + 32'd2, 32'h1111_2222);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mis_resp_valid", 32'(resp_valid), 32'd1);
        chk("mis_resp_err", 32'(resp_err), 32'd1);
        chk("mis_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        drive(1'b0, BASE - 32'd4, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("low_resp_err", 32'(resp_err), 32'd1);
        @(negedge clk);
        chk("err_no_bus", 32'(en_cnt), 32'(en_base));
        chk("err_bank0", bank[0], 32'hA5A5_0000);

        // Read register 7 with the response held off.
        resp_ready = 1'b0;
        drive(1'b0, BASE + 32'd28, 32'h0);
        @(negedge clk);
        drive(1'b0, BASE + 32'd4, 32'h0);
        chk("hold_acc_sel", 32'(reg_sel), 32'h80);
        @(negedge clk);
        chk("hold_resp_valid", 32'(resp_valid), 32'd1);
        chk("hold_resp_rdata", resp_rdata, 32'hA5A5_0007);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, 32'hA5A5_0007);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_reg_en", 32'(reg_en), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_resp_valid", 32'(resp_valid), 32'd0);
        chk("hs_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("second_reg_en", 32'(reg_en), 32'd1);
        chk("second_reg_sel", 32'(reg_sel), 32'h02);
        @(negedge clk);
        chk("second_rdata", resp_rdata, 32'hA5A5_0001);
        @(negedge clk);

        // Reset during the ACCESS cycle of a write to register 3.
        drive(1'b1, BASE + 32'd12, 32'h1234_5678);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsto_acc_reg_en", 32'(reg_en), 32'd1);
        chk("rsto_acc_reg_sel", 32'(reg_sel), 32'h08);
        #2 rstn = 1'b0;
        #1;
        chk("rsto_reg_en", 32'(reg_en), 32'd0);
        chk("rsto_reg_wr", 32'(reg_wr), 32'd0);
        chk("rsto_reg_sel", 32'(reg_sel), 32'd0);
        chk("rsto_reg_addr", reg_addr, 32'd0);
        chk("rsto_reg_wdata", reg_wdata, 32'd0);
        chk("rsto_resp_valid", 32'(resp_valid), 32'd0);
        chk("rsto_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rsto_no_resp", 32'(resp_valid), 32'd0);
        end
        chk("rsto_dropped", bank[3], 32'hA5A5_0003);
        drive(1'b0, BASE + 32'd12, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("post_rst_reg_en", 32'(reg_en), 32'd1);
        @(negedge clk);
        chk("post_rst_rdata", resp_rdata, 32'hA5A5_0003);
        chk("post_rst_err", 32'(resp_err), 32'd0);
        @(negedge clk);

        chk("bus_protocol", 32'(bus_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
